// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the bit-serial subtractor.
// The overflow signal exists only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic             overflow;

  modport master (output start, a, b, input busy, done, diff, borrow_out, overflow);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, overflow);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one full-subtractor cell + registered borrow.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_res;
  logic             r_bor;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;

  logic             w_d;
  logic             w_bor_nxt;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  assign w_d       = r_sa[0] ^ r_sb[0] ^ r_bor;
  assign w_bor_nxt = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_bor);
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  // Each new difference bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign w_res_nxt = {w_d, r_res};

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_overflow;
  logic w_ovf_nxt;

  // w_d on the last RUN edge is the result MSB.
  assign w_ovf_nxt = (r_a_msb != r_b_msb) & (w_d != r_a_msb);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && bus.start) begin
        r_a_msb <= bus.a[WIDTH-1];
        r_b_msb <= bus.b[WIDTH-1];
      end
      if (r_state == ST_RUN && w_last) r_overflow <= w_ovf_nxt;
    end
  end

  assign bus.overflow = r_overflow;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sa         <= '0;
      r_sb         <= '0;
      r_res        <= '0;
      r_bor        <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_bor   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_res <= w_res_nxt[WIDTH-1:1];
          r_bor <= w_bor_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff       <= w_res_nxt;
            r_borrow_out <= w_bor_nxt;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy       = (r_state == ST_RUN);
  assign bus.done       = (r_state == ST_DONE);
  assign bus.diff       = r_diff;
  assign bus.borrow_out = r_borrow_out;
endmodule
